// File: rtl/ln_arbiter_pkg.sv
// Shared types and constants for the ln arbiter slice: Q6.10 operand type and
// the ln(1+k/16) mantissa table used by the ln core.
package ln_pkg;

    typedef logic signed [15:0] q6_10_t;

    localparam int     Q_FRAC_BITS = 10;
    localparam q6_10_t Q_ONE       = 16'sh0400;
    localparam q6_10_t LN_NEG_SAT  = 16'sh8000;

    // ln(2) scaled by 2^16
    localparam logic [16:0] LN2_Q16 = 17'd45426;

    // ln(1 + k/16) scaled by 2^16, k = 0..16
    function automatic logic [16:0] ln_mant_q16(input logic [4:0] k);
        logic [16:0] v;
        case (k)
            5'd0:    v = 17'd0;
            5'd1:    v = 17'd3973;
            5'd2:    v = 17'd7719;
            5'd3:    v = 17'd11262;
            5'd4:    v = 17'd14624;
            5'd5:    v = 17'd17822;
            5'd6:    v = 17'd20870;
            5'd7:    v = 17'd23783;
            5'd8:    v = 17'd26573;
            5'd9:    v = 17'd29248;
            5'd10:   v = 17'd31818;
            5'd11:   v = 17'd34292;
            5'd12:   v = 17'd36675;
            5'd13:   v = 17'd38975;
            5'd14:   v = 17'd41197;
            5'd15:   v = 17'd43345;
            default: v = LN2_Q16;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ln_arbiter_ln_core.sv
// Combinational natural log, Q6.10 in and out. x = 2^e * m with m in [1,2);
// ln(m) is linearly interpolated over 16 segments. Non-positive x yields LN_NEG_SAT.
module ln_core
    import ln_pkg::*;
(
    input  q6_10_t x,
    output q6_10_t y
);

    logic [3:0]         lead;
    logic [13:0]        frac;
    logic [3:0]         seg;
    logic [9:0]         t;
    logic [16:0]        y0, y1, interp;
    logic [26:0]        prod;
    logic signed [31:0] acc, acc_r;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 15; i++) begin
            if (x[i]) lead = 4'(i);
        end
        // Leading one moved to bit 14 and dropped; the rest is the mantissa fraction
        frac   = 14'(x[14:0] << (4'd14 - lead));
        seg    = frac[13:10];
        t      = frac[9:0];
        y0     = ln_mant_q16({1'b0, seg});
        y1     = ln_mant_q16({1'b0, seg} + 5'd1);
        prod   = 27'(y1 - y0) * 27'(t);
        interp = y0 + 17'(prod >> 10);
        acc    = (32'(signed'({1'b0, lead})) - 32'sd10) * 32'(signed'({1'b0, LN2_Q16}))
               + 32'(signed'({1'b0, interp}));
        acc_r  = acc + 32'sd32;
        y      = (x > 16'sd0) ? q6_10_t'(acc_r >>> 6) : LN_NEG_SAT;
    end

endmodule

// File: rtl/ln_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer,
// pointer moves to the lane after the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (en && !gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

    // Explicit wrap so non-power-of-two lane counts stay in range
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/ln_arbiter.sv
// Shares one ln core between N_REQ lanes: round-robin grant, S1 operand register,
// S2 result register driving a tagged output bus. Optional macro: LN_ARB_DOMAIN_CHECK_EN.
module ln_arbiter
    import ln_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*16-1:0]   req_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_ln,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_err
);

    // Handshakes: a transfer happens on a clk edge where valid and ready are both 1.
    // req_ready depends only on req_valid, the rr pointer and pipeline space, never on
    // req_x; out_* hold stable while out_valid=1 and out_ready=0.

    logic              s1_valid_q, s1_valid_d;
    q6_10_t            s1_x_q, s1_x_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    q6_10_t            s2_ln_q, s2_ln_d;
    logic [ID_W-1:0]   s2_id_q, s2_id_d;
    logic              s2_err_q, s2_err_d;

    logic              s2_free, s1_free, s1_adv;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_vld;
    q6_10_t            gnt_x;
    q6_10_t            core_y;
    q6_10_t            s2_ln_in;
    logic              s2_err_in;

    assign s2_free = !s2_valid_q || out_ready;
    assign s1_free = !s1_valid_q || s2_free;
    assign s1_adv  = s1_valid_q && s2_free;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (s1_free && !rst),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt;
    assign gnt_x     = req_x[int'(gnt_id)*16 +: 16];

    ln_core u_core (
        .x (s1_x_q),
        .y (core_y)
    );

`ifdef LN_ARB_DOMAIN_CHECK_EN
    logic s1_dom_err;
    assign s1_dom_err = (s1_x_q <= 16'sd0);
    assign s2_ln_in   = s1_dom_err ? LN_NEG_SAT : core_y;
    assign s2_err_in  = s1_dom_err;
`else
    assign s2_ln_in   = core_y;
    assign s2_err_in  = 1'b0;
`endif

    always_comb begin
        s1_valid_d = gnt_vld || (s1_valid_q && !s2_free);
        s1_x_d     = gnt_vld ? gnt_x : s1_x_q;
        s1_id_d    = gnt_vld ? gnt_id : s1_id_q;
        s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
        s2_ln_d    = s1_adv ? s2_ln_in : s2_ln_q;
        s2_id_d    = s1_adv ? s1_id_q : s2_id_q;
        s2_err_d   = s1_adv ? s2_err_in : s2_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_ln_q    <= '0;
            s2_id_q    <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_ln_q    <= s2_ln_d;
            s2_id_q    <= s2_id_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_ln    = s2_ln_q;
    assign out_id    = s2_id_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_ln_arbiter.sv
// Bench for ln_arbiter: reference model of grant order and pipeline occupancy,
// expected results queued at grant and checked against real-valued ln at output.
module tb_ln_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int W     = ID_W + 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*16-1:0] req_x;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_ln;
    logic [ID_W-1:0]     out_id;
    logic                out_err;

    ln_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ln    (out_ln),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    bit m_s1 = 0;
    bit m_s2 = 0;
    int m_rr = 0;
    int last_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] rand_x();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'($urandom_range(32768, 65535));
        return 16'($urandom_range(1, 32767));
    endfunction

    task automatic set_lane(input int i, input bit v, input logic [15:0] x);
        req_valid[i]      = v;
        req_x[16*i +: 16] = x;
    endtask

    // ---------------- driver: one clock with model prediction ----------------
    task automatic cycle();
        bit s2f, s1f, n_s1, n_s2;
        int g;
        logic [N_REQ-1:0] er;
        @(negedge clk);
        s2f = !m_s2 || out_ready;
        s1f = !m_s1 || s2f;
        er  = '0;
        g   = -1;
        if (!rst && s1f) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_rr + k) % N_REQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_s2));
        check("rr_ptr", 32'(dut.u_arb.rr_ptr_q), 32'(m_rr));
        @(posedge clk);
        if (rst) begin
            m_s1 = 0;
            m_s2 = 0;
            m_rr = 0;
            exp_q.delete();
            g = -1;
        end else begin
            n_s2 = (m_s1 && s2f) || (m_s2 && !out_ready);
            n_s1 = (g >= 0) || (m_s1 && !s2f);
            if (g >= 0) begin
                exp_q.push_back({ID_W'(g), req_x[16*g +: 16]});
                m_rr = (g + 1) % N_REQ;
            end
            m_s1 = n_s1;
            m_s2 = n_s2;
        end
        last_g = g;
        #1;
    endtask

    // ---------------- monitor ----------------
    task automatic check_result(input logic [W-1:0] e);
        logic [ID_W-1:0]    eid;
        logic signed [15:0] ex;
        real                ideal;
        int                 diff;
        eid = e[W-1:16];
        ex  = e[15:0];
        check("out_id", 32'(out_id), 32'(eid));
        if (ex > 0) begin
            ideal = $ln(real'(ex) / 1024.0) * 1024.0;
            diff  = int'($signed(out_ln)) - int'(ideal);
            total++;
            if (diff > 3 || diff < -3) begin
                bad++;
                $display("FAIL out_ln x=%0h: got %0h, expected %0d +-3", ex, out_ln, int'(ideal));
            end
            check("out_err_pos", 32'(out_err), 32'd0);
        end else begin
            check("out_ln_sat", 32'(out_ln), 32'h8000);
`ifdef LN_ARB_DOMAIN_CHECK_EN
            check("out_err_dom", 32'(out_err), 32'd1);
`else
            check("out_err_dom", 32'(out_err), 32'd0);
`endif
        end
    endtask

    bit              prev_stall = 0;
    logic [15:0]     prev_ln;
    logic [ID_W-1:0] prev_id;
    logic            prev_err;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_ln", 32'(out_ln), 32'(prev_ln));
                check("hold_id", 32'(out_id), 32'(prev_id));
                check("hold_err", 32'(out_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d ln=%0h, expected none", out_id, out_ln);
                end else begin
                    check_result(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_ln    = out_ln;
            prev_id    = out_id;
            prev_err   = out_err;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ln", 32'(out_ln), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);

        // single lane 2, x = 1.0
        set_lane(2, 1, 16'h0400);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // all lanes at once
        set_lane(0, 1, 16'h0400);
        set_lane(1, 1, 16'h0800);
        set_lane(2, 1, 16'h0ADF);
        set_lane(3, 1, 16'h1400);
        repeat (4) begin
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        repeat (3) cycle();

        // backpressure: two grants, then everything stalls
        out_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_lane(i, 1, rand_x());
        repeat (7) begin
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        out_ready = 1'b1;
        req_valid = '0;
        repeat (4) cycle();

        // fairness: lanes 0 and 3 requesting continuously
        set_lane(0, 1, 16'h0C00);
        set_lane(3, 1, 16'h0200);
        repeat (8) begin
            cycle();
            if (last_g >= 0) req_x[16*last_g +: 16] = 16'($urandom_range(1, 32767));
        end
        req_valid = '0;
        repeat (3) cycle();

        // reset with both stages full
        out_ready = 1'b0;
        set_lane(1, 1, 16'h0500);
        set_lane(2, 1, 16'h0600);
        set_lane(3, 1, 16'h0700);
        repeat (3) begin
            cycle();
            if (last_g >= 0) req_x[16*last_g +: 16] = rand_x();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            cycle();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        repeat (3) cycle();

        // domain edge cases then a positive value
        set_lane(1, 1, 16'h0000);
        cycle();
        set_lane(1, 1, 16'hFC00);
        cycle();
        set_lane(1, 1, 16'h2800);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
            if (last_g >= 0) set_lane(last_g, ($urandom_range(0, 1) == 1), rand_x());
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) set_lane(i, 1, rand_x());
            end
        end

        // drain with a cycle budget
        req_valid = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (exp_q.size() != 0 || m_s1 || m_s2); n++) cycle();
        cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
